// File: rtl/instruction_fetch_if.sv
// Fetch-side bus: instruction memory port, branch redirect and decode handshake.
// master = fetch unit, slave = memory/decode/branch environment.
interface instruction_fetch_if #(
    parameter int unsigned N = 7
);
    logic [N-1:0] im_addr;
    logic [31:0]  im_data;
    logic         branch_taken;
    logic [N-1:0] branch_target;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_instr;
    logic [N-1:0] out_pc;

    modport master (
        output im_addr, out_valid, out_instr, out_pc,
        input  im_data, branch_taken, branch_target, out_ready
    );

    modport slave (
        input  im_addr, out_valid, out_instr, out_pc,
        output im_data, branch_taken, branch_target, out_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: owns the fetch PC, hides the one-cycle memory latency
// behind a 2-entry output FIFO and flushes on branch redirects.
module instruction_fetch #(
    parameter int unsigned   N        = 7,
    parameter logic [N-1:0]  RESET_PC = '0
) (
    input  logic                clka,
    input  logic                rst,
    instruction_fetch_if.master bus
);

    logic [N-1:0] fetch_pc;
    logic         inflight;
    logic [N-1:0] inflight_pc;
    logic [1:0]   occ;
    logic [31:0]  head_instr, tail_instr;
    logic [N-1:0] head_pc, tail_pc;

    logic         pop, push, issue;
    logic [2:0]   credit;

    assign bus.im_addr   = bus.branch_taken ? bus.branch_target : fetch_pc;
    assign bus.out_valid = (occ != 2'd0);
    assign bus.out_instr = head_instr;
    assign bus.out_pc    = head_pc;

    // A redirect voids any handshake and discards the response arriving this cycle.
    assign pop    = bus.out_valid & bus.out_ready & ~bus.branch_taken;
    assign push   = inflight & ~bus.branch_taken;
    assign credit = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign issue  = bus.branch_taken | (credit < 3'd2);

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            occ         <= 2'd0;
            head_instr  <= '0;
            head_pc     <= '0;
            tail_instr  <= '0;
            tail_pc     <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= bus.im_addr;
                fetch_pc    <= bus.im_addr + 1'b1;
            end

            if (bus.branch_taken) begin
                occ <= 2'd0;
            end else begin
                case ({push, pop})
                    2'b10: begin
                        if (occ == 2'd0) begin
                            head_instr <= bus.im_data;
                            head_pc    <= inflight_pc;
                        end else begin
                            tail_instr <= bus.im_data;
                            tail_pc    <= inflight_pc;
                        end
                        occ <= occ + 2'd1;
                    end
                    2'b01: begin
                        head_instr <= tail_instr;
                        head_pc    <= tail_pc;
                        occ        <= occ - 2'd1;
                    end
                    2'b11: begin
                        // Occupancy unchanged; the new word goes behind whatever remains.
                        if (occ == 2'd2) begin
                            head_instr <= tail_instr;
                            head_pc    <= tail_pc;
                            tail_instr <= bus.im_data;
                            tail_pc    <= inflight_pc;
                        end else begin
                            head_instr <= bus.im_data;
                            head_pc    <= inflight_pc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a stream-level reference model.
module tb_instruction_fetch;

    logic clka = 1'b0;
    logic rst  = 1'b1;
    always #5 clka = ~clka;

    instruction_fetch_if #(.N(7)) bus ();
    instruction_fetch_if #(.N(7)) bus2 ();

    instruction_fetch #(.N(7), .RESET_PC(7'd0)) dut (
        .clka (clka),
        .rst  (rst),
        .bus  (bus)
    );

    instruction_fetch #(.N(7), .RESET_PC(7'd126)) dut2 (
        .clka (clka),
        .rst  (rst),
        .bus  (bus2)
    );

    // Synchronous instruction memories: word k holds k.
    always @(posedge clka) bus.im_data  <= 32'(bus.im_addr);
    always @(posedge clka) bus2.im_data <= 32'(bus2.im_addr);

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Model: next expected PC of the in-order stream, plus edges since the last restart
    // (reset or redirect). Output becomes valid two edges after a restart and stays valid.
    int           k      = 0;
    logic [6:0]   exp_pc = 7'd0;

    always @(posedge clka or posedge rst) begin
        if (rst) begin
            k      = 0;
            exp_pc = 7'd0;
        end else if (bus.branch_taken) begin
            exp_pc = bus.branch_target;
            k      = 1;
        end else begin
            if (k >= 2 && bus.out_ready) exp_pc = exp_pc + 7'd1;
            if (k < 2) k = k + 1;
        end
    end

    always @(negedge clka) begin
        if (rst) begin
            chk("m_rst_valid", 32'(bus.out_valid), 32'd0);
            chk("m_rst_pc", 32'(bus.out_pc), 32'd0);
            chk("m_rst_instr", bus.out_instr, 32'd0);
        end else begin
            chk("m_valid", 32'(bus.out_valid), 32'(k >= 2));
            if (k >= 2) begin
                chk("m_pc", 32'(bus.out_pc), 32'(exp_pc));
                chk("m_instr", bus.out_instr, 32'(exp_pc));
            end
            chk("no_push_full", 32'(dut.push & (dut.occ == 2'd2)), 32'd0);
        end
    end

    task automatic step();
        @(negedge clka);
        #1;
    endtask

    task automatic wait_pc(input logic [6:0] pc, input string name);
        for (int c = 0; c < 40; c++) begin
            if (bus.out_valid && bus.out_pc == pc) break;
            step();
        end
        chk(name, 32'(bus.out_pc), 32'(pc));
    endtask

    // Second instance: wrap-around from RESET_PC = 126.
    initial begin
        logic [6:0] seq [4];
        int got;
        seq[0] = 7'd126; seq[1] = 7'd127; seq[2] = 7'd0; seq[3] = 7'd1;
        got = 0;
        bus2.out_ready     = 1'b1;
        bus2.branch_taken  = 1'b0;
        bus2.branch_target = 7'd0;
        @(negedge rst);
        for (int c = 0; c < 12 && got < 4; c++) begin
            @(negedge clka);
            if (bus2.out_valid) begin
                chk("wrap_pc", 32'(bus2.out_pc), 32'(seq[got]));
                chk("wrap_instr", bus2.out_instr, 32'(seq[got]));
                got++;
            end
        end
        chk("wrap_count", 32'(got), 32'd4);
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.out_ready     = 1'b1;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 7'd0;
        step();
        step();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_pc", 32'(bus.out_pc), 32'd0);
        chk("rst_instr", bus.out_instr, 32'd0);
        rst = 1'b0;

        step();
        chk("e0_valid", 32'(bus.out_valid), 32'd0);
        step();
        chk("e1_valid", 32'(bus.out_valid), 32'd1);
        chk("e1_pc", 32'(bus.out_pc), 32'd0);

        // Stall five cycles at PC 3.
        wait_pc(7'd3, "reach_pc3");
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_pc", 32'(bus.out_pc), 32'd3);
            chk("stall_addr", 32'(bus.im_addr), 32'd5);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("resume_pc", 32'(bus.out_pc), 32'(3 + i));
            step();
        end

        // Redirect while 10 is at the head and 11 is in flight.
        wait_pc(7'd10, "reach_pc10");
        bus.branch_taken  = 1'b1;
        bus.branch_target = 7'h40;
        #1;
        chk("redir_addr", 32'(bus.im_addr), 32'h40);
        step();
        bus.branch_taken = 1'b0;
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        step();
        chk("tgt_pc", 32'(bus.out_pc), 32'h40);
        step();
        chk("tgt_next_pc", 32'(bus.out_pc), 32'h41);

        // Redirect during a full stall.
        bus.out_ready = 1'b0;
        step();
        step();
        step();
        chk("full_valid", 32'(bus.out_valid), 32'd1);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 7'h10;
        step();
        bus.branch_taken = 1'b0;
        chk("stall_flush_valid", 32'(bus.out_valid), 32'd0);
        step();
        chk("stall_tgt_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_tgt_pc", 32'(bus.out_pc), 32'h10);
        chk("stall_tgt_instr", bus.out_instr, 32'h10);
        step();
        step();

        // Asynchronous reset mid-stream with a full buffer.
        rst = 1'b1;
        #1;
        chk("async_valid", 32'(bus.out_valid), 32'd0);
        chk("async_pc", 32'(bus.out_pc), 32'd0);
        #4;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        chk("restart_e0_valid", 32'(bus.out_valid), 32'd0);
        step();
        chk("restart_valid", 32'(bus.out_valid), 32'd1);
        chk("restart_pc", 32'(bus.out_pc), 32'd0);
        wait_pc(7'd5, "restart_pc5");
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch front end that drives the synchronous instruction memory and delivers instructions in program order to decode over a valid/ready handshake. It owns the fetch PC. It absorbs the memory's one-cycle read latency with a 2-entry output buffer, which gives one instruction per cycle when decode is ready and loses nothing under stalls. It also accepts branch redirects from later pipeline stages, flushing instructions fetched on the wrong path.

## Interface
- Parameters:
  - N, default 7: word-address width; must equal the instruction memory address width.
  - RESET_PC, default 0: first word address fetched after reset.
- Ports:
  - clka, in, 1: the only clock; all state changes on its rising edge.
  - rst, in, 1: asynchronous, active-high reset.
  - im_addr, out, N: word address to instruction memory addra.
  - im_data, in, 32: instruction memory douta; valid one cycle after the address was sampled.
  - branch_taken, in, 1: redirect request, single-cycle pulse.
  - branch_target, in, N: redirect word address, qualified by branch_taken.
  - out_valid, out, 1: out_instr/out_pc hold a valid instruction.
  - out_ready, in, 1: decode accepts the current instruction.
  - out_instr, out, 32: instruction word at the buffer head.
  - out_pc, out, N: word address of out_instr.

## Operation
- State:
  - fetch_pc (N bits): next address to fetch.
  - inflight flag + inflight_pc: a request was sampled at the previous edge; its data is on im_data this cycle.
  - 2-entry FIFO of {instr, pc}, occupancy occ in 0..2.
- im_addr (combinational) = branch_taken ? branch_target : fetch_pc.
- pop = out_valid & out_ready & ~branch_taken.
- issue = (branch_taken) | (occ + inflight - pop < 2). On issue:
  - inflight <= 1, inflight_pc <= im_addr.
  - fetch_pc <= im_addr + 1, modulo 2^N; 2^N-1 wraps to 0.
- No issue: inflight <= 0, fetch_pc unchanged. Memory still reads im_addr; that data is ignored.
- Response capture: if inflight & ~branch_taken, push {im_data, inflight_pc} into the FIFO at the edge.
- The credit rule guarantees occ never exceeds 2. A push into a full FIFO is impossible; the bench asserts it never occurs.
- Simultaneous push and pop: occupancy is unchanged and order is preserved (FIFO semantics).
- Redirect (branch_taken = 1) has priority over everything:
  - FIFO flushes (occ <= 0).
  - The in-flight response is discarded.
  - Any out_valid & out_ready handshake in that cycle is void; decode must treat it as not consumed.
  - The target is issued in the same cycle; fetch_pc <= branch_target + 1.
- out_valid = (occ != 0). out_instr/out_pc come from the FIFO head register and never come straight from im_data.
- Reset (asynchronous, any time) immediately forces:
  - fetch_pc = RESET_PC, inflight = 0, occ = 0, out_valid = 0.
  - out_instr = 0, out_pc = 0.
  - Any request in flight is dropped.

## Timing
- Edge E0 is the first rising edge with rst low. It samples im_addr = RESET_PC.
- out_valid rises after edge E1 with out_pc = RESET_PC. Issue-to-present latency is 2 edges.
- Throughput with out_ready held high: 1 instruction per cycle. Steady state is occ = 1, inflight = 1.
- out_ready low: at most one more response lands, then issue stops with occ = 2, inflight = 0.
- After out_ready reasserts, the stream resumes with no gaps and no duplicates.
- Redirect at edge Er: target instruction appears on out after edge Er+1. Wrong-path instructions never appear after Er.
- Redirect during a full stall: flush, and the target is fetched regardless of out_ready.

## Test plan
- Reset, then memory word k = k, out_ready = 1: out_valid rises after the 2nd edge. Then out_pc = 0, 1, 2, … one per cycle, out_instr = out_pc.
- Hold out_ready = 0 for 5 cycles starting when out_pc = 3: out_pc stays 3 and im_addr stays 5. After release, the sequence is 3, 4, 5, 6, … with no skips or repeats.
- branch_taken pulse with branch_target = 0x40 while PCs 10 and 11 are buffered/in flight: 10 and 11 never appear after the pulse. out_pc = 0x40 one edge later, then 0x41.
- RESET_PC = 126, N = 7, out_ready = 1: out_pc sequence is 126, 127, 0, 1.
- Assert rst for half a cycle mid-stream with occ = 2: out_valid drops immediately, without waiting for a clock edge. After release, the stream restarts from RESET_PC.
- Redirect to 0x10 while out_ready = 0 and occ = 2: FIFO empties, and out_pc = 0x10 one edge after the pulse. Check with out_ready still 0.
